countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 30 +++
 rtl/tick_gen.sv | 41 ++++
 rtl/countdown_timer.sv | 153 +++++++++++++++
 tb/tb_countdown_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, limits and preset clamps for the countdown timer
//
// Purpose: holds the timer state encoding and the field limits that the
// top level and the testbench agree on.
// Contents:
//   CENT_MAX, SEC_MAX, MIN_MAX  largest value of each time field
//   state_t                     IDLE / RUN / PAUSE / DONE
//   clamp_min, clamp_sec        limit an out-of-range preset to its field maximum
package timer_pkg;

  localparam int CENT_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [6:0] clamp_min(input logic [6:0] v);
    return (v > 7'(MIN_MAX)) ? 7'(MIN_MAX) : v;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] v);
    return (v > 6'(SEC_MAX)) ? 6'(SEC_MAX) : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clock divider producing one centisecond tick every CLK_DIV cycles
//
// Purpose: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears the count
//   en    count this cycle; when low the count is held
//   clr   synchronous clear to 0, wins over en
//   tick  high for the one cycle the count sits at CLK_DIV-1 while enabled
module tick_gen #(
  parameter int CLK_DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - min:sec:centisecond countdown timer with load/start/pause
//
// Purpose: counts a loaded min:sec preset down to 00:00:00 at one step per
// centisecond tick, then sits in DONE until a new preset is loaded.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   load     capture set_min/set_sec (clamped), centiseconds cleared; ignored in RUN
//   set_min  preset minutes 0..99
//   set_sec  preset seconds 0..59
//   start    begin or resume counting (level)
//   pause    suspend counting; wins over start
//   cent     remaining centiseconds
//   sec      remaining seconds
//   min      remaining minutes
//   running  high while in RUN
//   done     high while in DONE
//   expired  one-cycle pulse after the edge that enters DONE
module countdown_timer #(
  parameter int CLK_DIV = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] cent,
  output logic [5:0] sec,
  output logic [6:0] min,
  output logic       running,
  output logic       done,
  output logic       expired
);

  import timer_pkg::*;

  state_t     state, state_next;
  logic [6:0] cent_next, min_next;
  logic [5:0] sec_next;
  logic [6:0] dec_cent, dec_min;
  logic [5:0] dec_sec;
  logic       dec_zero, count_zero;
  logic       load_ok;
  logic       div_en, div_clr;
  logic       tick;

  assign load_ok    = load && (state != ST_RUN);
  assign count_zero = (cent == 7'd0) && (sec == 6'd0) && (min == 7'd0);

  // The divider only runs in RUN; leaving RUN for PAUSE keeps its phase so a
  // resume continues the partly elapsed centisecond.
  assign div_en  = (state == ST_RUN);
  assign div_clr = load_ok || (state == ST_IDLE) || (state == ST_DONE);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  // Borrowing decrement: each field only borrows from the next one up when it
  // is already zero, so no field can wrap below zero.
  always_comb begin
    dec_cent = cent;
    dec_sec  = sec;
    dec_min  = min;
    if (cent != 7'd0) begin
      dec_cent = cent - 7'd1;
    end else if (sec != 6'd0) begin
      dec_sec  = sec - 6'd1;
      dec_cent = 7'(CENT_MAX);
    end else if (min != 7'd0) begin
      dec_min  = min - 7'd1;
      dec_sec  = 6'(SEC_MAX);
      dec_cent = 7'(CENT_MAX);
    end
    dec_zero = (dec_cent == 7'd0) && (dec_sec == 6'd0) && (dec_min == 7'd0);
  end

  always_comb begin
    state_next = state;
    cent_next  = cent;
    sec_next   = sec;
    min_next   = min;
    if (load_ok) begin
      state_next = ST_IDLE;
      cent_next  = 7'd0;
      sec_next   = clamp_sec(set_sec);
      min_next   = clamp_min(set_min);
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !count_zero) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            cent_next = dec_cent;
            sec_next  = dec_sec;
            min_next  = dec_min;
            // Reaching zero takes priority over a simultaneous pause.
            if (dec_zero) begin
              state_next = ST_DONE;
            end else if (pause) begin
              state_next = ST_PAUSE;
            end
          end else if (pause) begin
            state_next = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cent    <= 7'd0;
      sec     <= 6'd0;
      min     <= 7'd0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      cent    <= cent_next;
      sec     <= sec_next;
      min     <= min_next;
      running <= (state_next == ST_RUN);
      done    <= (state_next == ST_DONE);
      expired <= (state == ST_RUN) && (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer against a total-centisecond model
module tb_countdown_timer;

  localparam int CLK_DIV = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [6:0] set_min;
  logic [5:0] set_sec;
  logic       start;
  logic       pause;
  logic [6:0] cent;
  logic [5:0] sec;
  logic [6:0] min;
  logic       running;
  logic       done;
  logic       expired;

  countdown_timer #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .set_min (set_min),
    .set_sec (set_sec),
    .start   (start),
    .pause   (pause),
    .cent    (cent),
    .sec     (sec),
    .min     (min),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: remaining time as one centisecond total, mode, and
  // the number of clocks spent in the current centisecond.
  int m_total;
  int m_mode;
  int m_phase;
  int m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0;
    m_mode  = M_IDLE;
    m_phase = 0;
    m_exp   = 0;
  endtask

  task automatic model_load(input int smin, input int ssec);
    int cm, cs;
    cm = (smin > 99) ? 99 : smin;
    cs = (ssec > 59) ? 59 : ssec;
    m_total = cm * 6000 + cs * 100;
    m_mode  = M_IDLE;
    m_phase = 0;
  endtask

  task automatic model_edge(input bit l, input int smin, input int ssec, input bit st, input bit pa);
    m_exp = 0;
    if (l && m_mode != M_RUN) begin
      model_load(smin, ssec);
    end else begin
      case (m_mode)
        M_IDLE: if (st && m_total > 0) begin
          m_mode  = M_RUN;
          m_phase = 0;
        end
        M_RUN: begin
          if (m_phase == CLK_DIV - 1) begin
            m_phase = 0;
            m_total = m_total - 1;
            if (m_total == 0) begin
              m_mode = M_DONE;
              m_exp  = 1;
            end else if (pa) begin
              m_mode = M_PAUSE;
            end
          end else begin
            m_phase = m_phase + 1;
            if (pa) m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (st && !pa) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input bit l, input int smin, input int ssec, input bit st, input bit pa);
    load    = l;
    set_min = 7'(smin);
    set_sec = 6'(ssec);
    start   = st;
    pause   = pa;
  endtask

  task automatic compare(input string tag);
    logic [31:0] exp_cnt, obs_cnt, exp_flags, obs_flags;
    exp_cnt   = {11'd0, 7'(m_total / 6000), 6'((m_total / 100) % 60), 7'(m_total % 100)};
    obs_cnt   = {11'd0, min, sec, cent};
    exp_flags = {29'd0, (m_mode == M_RUN), (m_mode == M_DONE), (m_exp != 0)};
    obs_flags = {29'd0, running, done, expired};
    check({tag, ".count"}, obs_cnt, exp_cnt);
    check({tag, ".flags"}, obs_flags, exp_flags);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(load, int'(set_min), int'(set_sec), start, pause);
    #1;
    compare(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int pulses;
    int done_at;
    logic [31:0] held;

    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    check("reset.count", {min, sec, cent}, 32'd0);
    check("reset.flags", {running, done, expired}, 32'd0);
    rst = 1'b0;

    // 00:02 run to completion
    drive(1, 0, 2, 0, 0);
    step("load_0002");
    drive(0, 0, 0, 1, 0);
    step("start_0002");
    check("run_entry", running, 1'b1);
    drive(0, 0, 0, 0, 0);
    pulses  = 0;
    done_at = -1;
    for (int k = 1; k <= 800; k++) begin
      step("run_0002");
      if (k == 3) check("before_first_tick", {sec, cent}, {6'd2, 7'd0});
      if (k == 4) check("first_tick", {sec, cent}, {6'd1, 7'd99});
      if (expired) pulses++;
      if (done && done_at < 0) done_at = k;
    end
    steps("after_done", 3);
    if (expired) pulses++;
    check("done_cycle", done_at, 800);
    check("expired_pulses", pulses, 1);

    // DONE ignores start, then reloads
    drive(0, 0, 0, 1, 0);
    steps("done_start", 20);
    check("done_hold", {done, min, sec, cent}, {1'b1, 20'd0});
    drive(1, 0, 1, 0, 0);
    step("done_load");
    check("done_cleared", done, 1'b0);

    // 01:00 borrows into 00:59:99
    drive(1, 1, 0, 0, 0);
    step("load_0100");
    drive(0, 0, 0, 1, 0);
    step("start_0100");
    drive(0, 0, 0, 0, 0);
    steps("run_0100", 4);
    check("borrow_min", {min, sec, cent}, {7'd0, 6'd59, 7'd99});

    // load while running is ignored
    drive(1, 5, 5, 0, 0);
    steps("load_in_run", 2);

    // pause at divider phase 2, hold, resume
    drive(0, 0, 0, 0, 1);
    step("pause_a");
    drive(1, 0, 5, 0, 0);
    step("reload_0005");
    drive(0, 0, 0, 1, 0);
    step("start_0005");
    drive(0, 0, 0, 0, 0);
    step("phase1");
    drive(0, 0, 0, 0, 1);
    step("pause_phase2");
    check("paused", running, 1'b0);
    held = {min, sec, cent};
    drive(0, 0, 0, 0, 0);
    steps("paused_hold", 10);
    check("pause_frozen", {min, sec, cent}, held);
    drive(0, 0, 0, 1, 0);
    step("resume");
    drive(0, 0, 0, 0, 0);
    step("resume_1");
    check("resume_no_tick", cent, 7'd0);
    step("resume_2");
    check("resume_tick", {sec, cent}, {6'd4, 7'd99});

    // clamp and zero-preset start
    drive(0, 0, 0, 0, 1);
    step("pause_b");
    drive(1, 120, 63, 0, 0);
    step("clamp_load");
    check("clamp", {min, sec}, {7'd99, 6'd59});
    drive(1, 0, 0, 0, 0);
    step("zero_load");
    drive(0, 0, 0, 1, 0);
    steps("zero_start", 3);
    check("zero_no_run", running, 1'b0);

    // asynchronous reset mid-run
    drive(1, 0, 3, 0, 0);
    step("load_0003");
    drive(0, 0, 0, 1, 0);
    steps("run_0003", 7);
    #3 rst = 1'b1;
    #1;
    check("async_rst.count", {min, sec, cent}, 32'd0);
    check("async_rst.flags", {running, done, expired}, 32'd0);
    model_reset();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    steps("after_rst", 3);

    // load and start together: load wins
    drive(1, 0, 4, 1, 0);
    step("load_start");
    check("load_start_idle", running, 1'b0);
    drive(0, 0, 0, 1, 0);
    step("start_next");
    check("start_next_run", running, 1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit l, st, pa;
      int sm, ss;
      l  = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 30);
      pa = ($urandom_range(0, 99) < 8);
      sm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : 0;
      ss = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
      drive(l, sm, ss, st, pa);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
